// File: rtl/pulse_period_monitor.sv
// Purpose: checks a periodic one-cycle pulse train; measures intervals, declares lock, flags early/late pulses.
// Latency: all outputs registered, updated on the edge that samples the triggering PIN/counter condition.
// Backpressure: none; PIN is sampled every cycle and cannot be stalled. Optional macro: PULSE_MON_ERR_CNT_EN.
module pulse_period_monitor #(
  parameter int PERIOD = 256,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 10
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             PIN,
  input  logic             CLR,
  output logic             LOCK,
  output logic [CNT_W-1:0] IVAL,
  output logic             IVAL_VLD,
  output logic             ERR_EARLY,
  output logic             ERR_LATE,
  output logic [7:0]       ERR_CNT
);

  localparam logic [CNT_W-1:0] LO_C   = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_C   = CNT_W'(PERIOD + TOL);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_N);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_run;

  logic       ref_ok;
  logic       is_early;
  logic       is_late;
  logic [3:0] run_inc;

  // A reference pulse exists outside SEARCH; early/late only make sense against it.
  assign ref_ok   = (state != SEARCH);
  assign is_early = ref_ok & PIN & (cnt < LO_C);
  assign is_late  = ref_ok & ~PIN & (cnt == HI_C);
  // Good-run count saturates at LOCK_N so it never wraps while locked.
  assign run_inc  = (good_run == LOCK_C) ? good_run : good_run + 4'd1;

  // Interval FSM: counter, good-run tracking, lock and measurement/error strobes.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= SEARCH;
      cnt       <= '0;
      good_run  <= '0;
      LOCK      <= 1'b0;
      IVAL      <= '0;
      IVAL_VLD  <= 1'b0;
      ERR_EARLY <= 1'b0;
      ERR_LATE  <= 1'b0;
    end else begin
      IVAL_VLD  <= 1'b0;
      ERR_EARLY <= 1'b0;
      ERR_LATE  <= 1'b0;
      case (state)
        SEARCH: begin
          // First pulse only establishes the reference; nothing is measured.
          if (PIN) begin
            cnt   <= CNT_W'(1);
            state <= ACQUIRE;
          end
        end
        default: begin
          if (PIN) begin
            cnt      <= CNT_W'(1);
            IVAL     <= cnt;
            IVAL_VLD <= 1'b1;
            if (is_early) begin
              // Early pulse restarts acquisition using itself as the new reference.
              ERR_EARLY <= 1'b1;
              good_run  <= '0;
              state     <= ACQUIRE;
              LOCK      <= 1'b0;
            end else begin
              good_run <= run_inc;
              if (run_inc == LOCK_C) begin
                state <= LOCKED;
                LOCK  <= 1'b1;
              end
            end
          end else if (is_late) begin
            // Window closed without a pulse: drop the reference entirely.
            ERR_LATE <= 1'b1;
            good_run <= '0;
            cnt      <= '0;
            state    <= SEARCH;
            LOCK     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PULSE_MON_ERR_CNT_EN
  logic err_hit;
  assign err_hit = is_early | is_late;

  // Saturating error count; a clear that coincides with an error leaves exactly that error counted.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ERR_CNT <= '0;
    end else if (CLR) begin
      ERR_CNT <= err_hit ? 8'd1 : 8'd0;
    end else if (err_hit && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = CLR;
  assign ERR_CNT    = '0;
`endif

endmodule

// File: doc/pulse_period_monitor.md
# pulse_period_monitor

Receiving-end checker for the periodic one-cycle pulse train produced by the on-chip oscillator/prescaler (default period 256 clocks). Measures the cycle distance between consecutive pulses, declares lock after a run of in-tolerance intervals, and flags early or missing pulses. Sits on the same clock domain as the pulse source and feeds status to the supervisor/watchdog logic.

## Interface
- PERIOD, 256, nominal pulse interval in clocks
- TOL, 2, allowed ± deviation in clocks; constraint 0 ≤ TOL < PERIOD-1
- LOCK_N, 4, consecutive good intervals required for lock; range 1..15
- CNT_W, 10, interval counter width; must hold PERIOD+TOL
- CLK  in  1  system clock, rising edge
- RN  in  1  reset, asynchronous, active-low
- PIN  in  1  pulse input, synchronous to CLK; each sampled-high cycle is one pulse
- CLR  in  1  synchronous clear of the error counter
- LOCK  out  1  high while in LOCKED
- IVAL  out  CNT_W  last measured interval
- IVAL_VLD  out  1  one-cycle strobe when IVAL updates
- ERR_EARLY  out  1  one-cycle strobe: interval < PERIOD-TOL
- ERR_LATE  out  1  one-cycle strobe: no pulse within PERIOD+TOL
- ERR_CNT  out  8  saturating error count (see Configuration)

## Operation
- Counter cnt: cycles since last pulse. Pulse sampled → cnt <= 1; otherwise cnt <= cnt+1 when a reference exists. Value of cnt in a pulse cycle = interval.
- States: SEARCH (no reference), ACQUIRE (reference held, good run < LOCK_N), LOCKED.
- SEARCH: cnt held 0; pulse → cnt <= 1, ACQUIRE. No measurement, no strobes.
- ACQUIRE/LOCKED, pulse with PERIOD-TOL ≤ cnt ≤ PERIOD+TOL (good): IVAL <= cnt, IVAL_VLD; good_run++ (saturate at LOCK_N); ACQUIRE → LOCKED when good_run reaches LOCK_N; LOCKED stays.
- ACQUIRE/LOCKED, pulse with cnt < PERIOD-TOL (early): IVAL <= cnt, IVAL_VLD, ERR_EARLY; good_run <= 0; state ACQUIRE; pulse becomes new reference (cnt <= 1).
- ACQUIRE/LOCKED, PIN low with cnt == PERIOD+TOL (late): ERR_LATE; good_run <= 0; cnt <= 0; state SEARCH. IVAL unchanged.
- PIN held high several cycles: second and later cycles are pulses with interval 1 → early.
- Reset (RN low, any time, mid-interval included): state SEARCH, cnt 0, good_run 0, all outputs 0, IVAL 0, ERR_CNT 0; effective immediately, no clock needed.

## Timing
- All outputs registered; strobes/LOCK/IVAL assert on the CLK edge that samples the triggering PIN/cnt condition; strobes last exactly one cycle.
- LOCK rises on the edge sampling the LOCK_N-th consecutive good pulse; falls on the edge flagging early or late.
- Boundaries: interval PERIOD-TOL and PERIOD+TOL are good; PERIOD-TOL-1 early; pulse at PERIOD+TOL+1 arrives after ERR_LATE and is treated as SEARCH's first pulse.
- First pulse after reset produces no IVAL_VLD; first measurement is on the second pulse.
- RN deassertion assumed synchronized externally; first active edge may sample PIN.

## Configuration
- PULSE_MON_ERR_CNT_EN defined: ERR_CNT increments by 1 per ERR_EARLY or ERR_LATE strobe, saturates at 255; CLR clears it next edge; CLR coincident with an error → ERR_CNT = 1.
- Undefined: ERR_CNT tied to 0, CLR ignored, counter logic removed; all other behaviour identical.

## Test plan
- Reset, pulses every 256 clocks ×6 → IVAL_VLD from 2nd pulse, IVAL=256, LOCK high on edge of 5th pulse, no errors.
- While locked, one pulse at 258 then 259 → first good (IVAL=258, LOCK stays); second: ERR_LATE at cnt 258 with PIN low, LOCK 0, state SEARCH, no IVAL_VLD for the 259 pulse.
- While locked, pulse at 253 → IVAL=253, ERR_EARLY, LOCK 0; following 256-spaced pulses relock after 4 more good intervals.
- PIN high 2 consecutive cycles while locked → ERR_EARLY with IVAL=1, ERR_CNT=1 (macro on).
- With macro on: 300 early errors → ERR_CNT=255; CLR same cycle as an error → ERR_CNT=1; macro off → ERR_CNT stays 0.
- RN low mid-interval during LOCKED → all outputs 0 immediately; after release, first pulse gives no IVAL_VLD, second at 256 → IVAL=256.
